// File: rtl/pio_button_poller_pkg.sv
// Shared definitions for the PIO button poller: FSM states, PIO register
// offsets and the slave read latency.
package pio_poller_pkg;

  // Poller FSM states; MASK_WR is only reachable when the mask-clear
  // feature is compiled in.
  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    MASK_WR = 2'd3
  } state_t;

  // Word offsets of the PIO slave registers we touch.
  localparam logic [1:0] DATA_OFS    = 2'd0;
  localparam logic [1:0] IRQMASK_OFS = 2'd2;

  // The PIO slave returns read data one cycle after acceptance.
  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/pio_button_poller_if.sv
// Avalon-MM master/slave bundle between the poller and the PIO slave.
interface pio_button_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/pio_button_poller_debounce.sv
// Sample-based debouncer: a new value must be seen on DEBOUNCE_COUNT
// consecutive polls before it becomes the debounced state. Rising edges of
// the debounced state are reported as one-cycle press pulses.
module pio_debounce #(
  parameter int WIDTH          = 1,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_sample_valid,
  input  logic [WIDTH-1:0] i_sample,
  output logic [WIDTH-1:0] o_btn_state,
  output logic [WIDTH-1:0] o_btn_press
);

  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_COUNT);

  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_btnState;
  logic [WIDTH-1:0] r_btnPress;

  logic [WIDTH-1:0] w_candNext;
  logic [CW-1:0]    w_cntNext;
  logic [WIDTH-1:0] w_stateNext;

  // Evaluate the candidate/counter update for the current sample; the
  // debounced state commits in the same cycle the counter reaches the limit.
  always_comb begin
    w_candNext  = r_cand;
    w_cntNext   = r_cnt;
    w_stateNext = r_btnState;
    if (i_sample_valid) begin
      if (i_sample == r_cand) begin
        if (r_cnt != CNT_MAX) begin
          w_cntNext = r_cnt + CW'(1);
        end
      end else begin
        w_candNext = i_sample;
        w_cntNext  = CW'(1);
      end
      if (w_cntNext == CNT_MAX) begin
        w_stateNext = w_candNext;
      end
    end
  end

  // Register debounce state; the press pulse is nonzero only in the cycle
  // the debounced state actually rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand     <= '0;
      r_cnt      <= '0;
      r_btnState <= '0;
      r_btnPress <= '0;
    end else begin
      r_cand     <= w_candNext;
      r_cnt      <= w_cntNext;
      r_btnState <= w_stateNext;
      r_btnPress <= w_stateNext & ~r_btnState;
    end
  end

  assign o_btn_state = r_btnState;
  assign o_btn_press = r_btnPress;

endmodule

// File: rtl/pio_button_poller.sv
// Avalon-MM master that polls the data register of a PIO input slave and
// debounces the result into btn_state / btn_press for fabric logic.
// Optional feature macro: PIO_BUTTON_POLLER_MASK_CLEAR_EN -- when defined,
// the first transaction after reset writes 0 to the PIO irq_mask register.
module pio_button_poller
  import pio_poller_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int POLL_CYCLES    = 50000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  pio_button_poller_if.master avm,
  input  logic                enable,
  output logic [WIDTH-1:0]    btn_state,
  output logic [WIDTH-1:0]    btn_press,
  output logic                busy
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);

`ifdef PIO_BUTTON_POLLER_MASK_CLEAR_EN
  localparam state_t RESET_STATE = MASK_WR;
`else
  localparam state_t RESET_STATE = WAIT;
`endif

  state_t        r_state;
  state_t        w_nextState;
  logic [TW-1:0] r_timer;
  logic          w_timerDone;
  logic          w_read;
  logic          w_write;
  logic [1:0]    w_address;
  logic          w_busy;
  logic          w_sampleValid;
  logic          w_unused_readdata;

  assign w_timerDone = (r_timer == TIMER_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: poll on timer expiry, wait out stalls, one data cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      WAIT: begin
        if (w_timerDone && enable) begin
          w_nextState = RD_REQ;
        end
      end
      RD_REQ: begin
        if (!avm.avm_waitrequest) begin
          w_nextState = RD_DATA;
        end
      end
      RD_DATA: begin
        w_nextState = WAIT;
      end
      MASK_WR: begin
`ifdef PIO_BUTTON_POLLER_MASK_CLEAR_EN
        if (!avm.avm_waitrequest) begin
          w_nextState = WAIT;
        end
`else
        w_nextState = WAIT;
`endif
      end
      default: begin
        w_nextState = WAIT;
      end
    endcase
  end

  // Output decode: master signals depend only on the current state, so they
  // stay stable for as long as the slave stalls.
  always_comb begin
    w_read    = 1'b0;
    w_write   = 1'b0;
    w_address = DATA_OFS;
    w_busy    = 1'b0;
    case (r_state)
      RD_REQ: begin
        w_read    = 1'b1;
        w_address = DATA_OFS;
        w_busy    = 1'b1;
      end
      RD_DATA: begin
        w_busy = 1'b1;
      end
`ifdef PIO_BUTTON_POLLER_MASK_CLEAR_EN
      MASK_WR: begin
        w_write   = 1'b1;
        w_address = IRQMASK_OFS;
        w_busy    = 1'b1;
      end
`endif
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Poll timer: counts from read acceptance so stalls stretch the period;
  // parks at its last value while polling is disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else begin
      case (r_state)
        WAIT: begin
          if (w_timerDone) begin
            if (enable) begin
              r_timer <= '0;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        RD_REQ: begin
          if (!avm.avm_waitrequest) begin
            r_timer <= TW'(1);
          end
        end
        RD_DATA: begin
          r_timer <= r_timer + TW'(1);
        end
        default: begin
          r_timer <= '0;
        end
      endcase
    end
  end

  assign avm.avm_read      = w_read;
  assign avm.avm_write     = w_write;
  assign avm.avm_address   = w_address;
  assign avm.avm_writedata = 32'd0;
  assign busy              = w_busy;

  // Read data arrives RD_LATENCY cycles after acceptance, i.e. in RD_DATA.
  assign w_sampleValid     = (r_state == RD_DATA) && (RD_LATENCY == 1);
  assign w_unused_readdata = ^avm.avm_readdata;

  pio_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
  ) u_debounce (
    .clk            (clk),
    .reset          (reset),
    .i_sample_valid (w_sampleValid),
    .i_sample       (avm.avm_readdata[WIDTH-1:0]),
    .o_btn_state    (btn_state),
    .o_btn_press    (btn_press)
  );

endmodule

// File: tb/tb_pio_button_poller.sv
// Directed testbench for pio_button_poller (WIDTH=2, POLL_CYCLES=8,
// DEBOUNCE_COUNT=4). Honours PIO_BUTTON_POLLER_MASK_CLEAR_EN when defined.
module tb_pio_button_poller;

  localparam int WIDTH = 2;
  localparam int POLL  = 8;
  localparam int DEB   = 4;

`ifdef PIO_BUTTON_POLLER_MASK_CLEAR_EN
  localparam bit MASKCLR = 1'b1;
`else
  localparam bit MASKCLR = 1'b0;
`endif
  localparam logic [1:0] RST_ADDR = MASKCLR ? 2'd2 : 2'd0;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] btn_state;
  logic [WIDTH-1:0] btn_press;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  pio_button_poller_if avm_if ();

  pio_button_poller #(
    .WIDTH          (WIDTH),
    .POLL_CYCLES    (POLL),
    .DEBOUNCE_COUNT (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .avm       (avm_if),
    .enable    (enable),
    .btn_state (btn_state),
    .btn_press (btn_press),
    .busy      (busy)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Wait (bounded) until avm_read is observed high.
  task automatic waitForRead(input string tag);
    for (int i = 0; i < 64 && avm_if.avm_read !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (avm_if.avm_read !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_read_timeout: avm_read=%b expected 1", tag, avm_if.avm_read);
    end
  endtask

  // Count negedges until avm_read is seen high (bounded).
  task automatic countToRead(output int n);
    n = 0;
    while (avm_if.avm_read !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One poll: answer the next read with val (upper bits garbage) and return
  // the debounced outputs in the cycle after the data phase.
  task automatic pollOnce(input logic [WIDTH-1:0] val,
                          output logic [WIDTH-1:0] st,
                          output logic [WIDTH-1:0] pr);
    waitForRead("poll");
    avm_if.avm_waitrequest = 1'b0;
    avm_if.avm_readdata    = {30'h2D5A_F3C1, val};
    @(negedge clk);
    @(negedge clk);
    st = btn_state;
    pr = btn_press;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    enable = 1'b1;
    avm_if.avm_waitrequest = 1'b0;
    avm_if.avm_readdata = 32'd0;
    repeat (3) @(negedge clk);
    vectors += 7;
    if (avm_if.avm_read !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_read: got %b expected 0", avm_if.avm_read); end
    if (avm_if.avm_write !== MASKCLR) begin miscompares++; $display("[TB] FAIL rst_write: got %b expected %b", avm_if.avm_write, MASKCLR); end
    if (avm_if.avm_address !== RST_ADDR) begin miscompares++; $display("[TB] FAIL rst_addr: got %0d expected %0d", avm_if.avm_address, RST_ADDR); end
    if (avm_if.avm_writedata !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_wdata: got %h expected 0", avm_if.avm_writedata); end
    if (btn_state !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_state: got %b expected 00", btn_state); end
    if (btn_press !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_press: got %b expected 00", btn_press); end
    if (busy !== MASKCLR) begin miscompares++; $display("[TB] FAIL rst_busy: got %b expected %b", busy, MASKCLR); end
    reset = 1'b0;
    countToRead(n);
    vectors++;
    if (n != POLL + int'(MASKCLR)) begin miscompares++; $display("[TB] FAIL first_poll: got %0d cycles expected %0d", n, POLL + int'(MASKCLR)); end
  endtask

  task automatic test_poll_period();
    int n;
    int writes;
    for (int rep = 0; rep < 2; rep++) begin
      waitForRead("period");
      vectors += 2;
      if (avm_if.avm_address !== 2'd0) begin miscompares++; $display("[TB] FAIL poll_addr: got %0d expected 0", avm_if.avm_address); end
      if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL poll_busy: got %b expected 1", busy); end
      @(negedge clk);
      vectors++;
      if (avm_if.avm_read !== 1'b0) begin miscompares++; $display("[TB] FAIL read_pulse: got %b expected 0", avm_if.avm_read); end
      n = 0;
      writes = 0;
      while (avm_if.avm_read !== 1'b1 && n < 64) begin
        if (avm_if.avm_write !== 1'b0) writes++;
        @(negedge clk);
        n++;
      end
      vectors += 2;
      if (n != POLL - 1) begin miscompares++; $display("[TB] FAIL poll_period: got %0d expected %0d", n + 1, POLL); end
      if (writes != 0) begin miscompares++; $display("[TB] FAIL write_idle: got %0d write cycles expected 0", writes); end
    end
  endtask

  task automatic test_enable();
    int reads;
    waitForRead("enable");
    enable = 1'b0;
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avm_if.avm_read === 1'b1) reads++;
    end
    vectors++;
    if (reads != 0) begin miscompares++; $display("[TB] FAIL enable_low: got %0d read cycles expected 0", reads); end
    enable = 1'b1;
    @(negedge clk);
    vectors++;
    if (avm_if.avm_read !== 1'b1) begin miscompares++; $display("[TB] FAIL enable_rise: avm_read=%b expected 1", avm_if.avm_read); end
  endtask

  task automatic test_debounce_basic();
    logic [WIDTH-1:0] st, pr;
    logic [WIDTH-1:0] expSt [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    logic [WIDTH-1:0] expPr [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      pollOnce(2'b01, st, pr);
      vectors += 2;
      if (st !== expSt[i]) begin miscompares++; $display("[TB] FAIL basic_state[%0d]: got %b expected %b", i, st, expSt[i]); end
      if (pr !== expPr[i]) begin miscompares++; $display("[TB] FAIL basic_press[%0d]: got %b expected %b", i, pr, expPr[i]); end
    end
    @(negedge clk);
    vectors += 2;
    if (btn_press !== 2'b00) begin miscompares++; $display("[TB] FAIL press_width: got %b expected 00", btn_press); end
    if (btn_state !== 2'b01) begin miscompares++; $display("[TB] FAIL state_hold: got %b expected 01", btn_state); end
  endtask

  task automatic test_glitch();
    logic [WIDTH-1:0] st, pr;
    logic [WIDTH-1:0] seq   [11] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11,
                                     2'b00, 2'b00, 2'b00, 2'b00};
    logic [WIDTH-1:0] expSt [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11,
                                     2'b11, 2'b11, 2'b11, 2'b00};
    logic [WIDTH-1:0] expPr [11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
                                     2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 11; i++) begin
      pollOnce(seq[i], st, pr);
      vectors += 2;
      if (st !== expSt[i]) begin miscompares++; $display("[TB] FAIL glitch_state[%0d]: got %b expected %b", i, st, expSt[i]); end
      if (pr !== expPr[i]) begin miscompares++; $display("[TB] FAIL glitch_press[%0d]: got %b expected %b", i, pr, expPr[i]); end
    end
  endtask

  task automatic test_stall();
    int held;
    int n;
    waitForRead("stall");
    avm_if.avm_waitrequest = 1'b1;
    avm_if.avm_readdata = 32'hFFFF_FFFC;
    held = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (avm_if.avm_read === 1'b1 && avm_if.avm_address === 2'd0 && busy === 1'b1) held++;
    end
    vectors++;
    if (held != 6) begin miscompares++; $display("[TB] FAIL stall_hold: got %0d stable cycles expected 6", held); end
    avm_if.avm_waitrequest = 1'b0;
    avm_if.avm_readdata = 32'h5A5A_5A5B;
    @(negedge clk);
    vectors += 2;
    if (avm_if.avm_read !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_release: avm_read=%b expected 0", avm_if.avm_read); end
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_data_busy: got %b expected 1", busy); end
    countToRead(n);
    vectors++;
    if (n != POLL - 1) begin miscompares++; $display("[TB] FAIL stall_period: got %0d after acceptance expected %0d", n + 1, POLL); end
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] st, pr;
    logic [WIDTH-1:0] expSt [3] = '{2'b00, 2'b00, 2'b11};
    logic [WIDTH-1:0] expPr [3] = '{2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 3; i++) begin
      pollOnce(2'b11, st, pr);
      vectors += 2;
      if (st !== expSt[i]) begin miscompares++; $display("[TB] FAIL simul_state[%0d]: got %b expected %b", i, st, expSt[i]); end
      if (pr !== expPr[i]) begin miscompares++; $display("[TB] FAIL simul_press[%0d]: got %b expected %b", i, pr, expPr[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    waitForRead("midreset");
    avm_if.avm_waitrequest = 1'b1;
    @(negedge clk);
    vectors += 2;
    if (avm_if.avm_read !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_stalled: avm_read=%b expected 1", avm_if.avm_read); end
    if (btn_state !== 2'b11) begin miscompares++; $display("[TB] FAIL mid_pre_state: got %b expected 11", btn_state); end
    reset = 1'b1;
    @(negedge clk);
    vectors += 4;
    if (avm_if.avm_read !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_read: got %b expected 0", avm_if.avm_read); end
    if (busy !== MASKCLR) begin miscompares++; $display("[TB] FAIL mid_busy: got %b expected %b", busy, MASKCLR); end
    if (btn_state !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_state: got %b expected 00", btn_state); end
    if (btn_press !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_press: got %b expected 00", btn_press); end
    reset = 1'b0;
    avm_if.avm_waitrequest = 1'b0;
    countToRead(n);
    vectors++;
    if (n != POLL + int'(MASKCLR)) begin miscompares++; $display("[TB] FAIL mid_restart: got %0d cycles expected %0d", n, POLL + int'(MASKCLR)); end
  endtask

`ifdef PIO_BUTTON_POLLER_MASK_CLEAR_EN
  task automatic test_mask_clear();
    int good;
    int n;
    reset = 1'b1;
    avm_if.avm_waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    good = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (avm_if.avm_write === 1'b1 && avm_if.avm_address === 2'd2 &&
          avm_if.avm_writedata === 32'd0 && avm_if.avm_read === 1'b0 && busy === 1'b1) good++;
    end
    vectors++;
    if (good != 3) begin miscompares++; $display("[TB] FAIL mask_write: got %0d good cycles expected 3", good); end
    avm_if.avm_waitrequest = 1'b0;
    @(negedge clk);
    vectors += 2;
    if (avm_if.avm_write !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_done: avm_write=%b expected 0", avm_if.avm_write); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_busy: got %b expected 0", busy); end
    countToRead(n);
    vectors++;
    if (n != POLL) begin miscompares++; $display("[TB] FAIL mask_first_poll: got %0d cycles expected %0d", n, POLL); end
  endtask
`endif

  // Run the directed scenarios in order, then report.
  initial begin
    reset = 1'b1;
    enable = 1'b1;
    avm_if.avm_waitrequest = 1'b0;
    avm_if.avm_readdata = 32'd0;
    test_reset();
    test_poll_period();
    test_enable();
    test_debounce_basic();
    test_glitch();
    test_stall();
    test_simultaneous();
    test_reset_mid();
`ifdef PIO_BUTTON_POLLER_MASK_CLEAR_EN
    test_mask_clear();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
